// File: rtl/button_event_decoder.sv
// Turns a debounced, synchronous button level into one-cycle press/click/double/long events.
// Optional double-click support is compiled in with `define BTN_DOUBLE_CLICK_EN.
module button_event_decoder #(
  parameter int LONG_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int CNT_W       = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_state,
  output logic press_pulse,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic btn_held
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
`ifdef BTN_DOUBLE_CLICK_EN
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
`endif
    LONG   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             btn_q;
  logic             rise;
  logic             press_n, single_n, double_n, long_n, held_n;

  // btn_q resets high so a button held through reset yields no rise.
  assign rise = btn_state & ~btn_q;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    press_n  = 1'b0;
    single_n = 1'b0;
    double_n = 1'b0;
    long_n   = 1'b0;
    held_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          press_n = 1'b1;
          cnt_n   = CNT_W'(1);
          state_n = PRESS1;
        end
      end
      PRESS1: begin
        if (btn_state) begin
          if (cnt == LONG_LAST) begin
            long_n  = 1'b1;
            state_n = LONG;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else begin
`ifdef BTN_DOUBLE_CLICK_EN
          cnt_n   = CNT_W'(1);
          state_n = WAIT2;
`else
          single_n = 1'b1;
          state_n  = IDLE;
`endif
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      WAIT2: begin
        if (rise) begin
          press_n = 1'b1;
          state_n = PRESS2;
        end else if (cnt == GAP_LAST) begin
          single_n = 1'b1;
          state_n  = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PRESS2: begin
        if (!btn_state) begin
          double_n = 1'b1;
          state_n  = IDLE;
        end
      end
`endif
      LONG: begin
        if (!btn_state) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    held_n = (state_n == LONG);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_q        <= 1'b1;
      press_pulse  <= 1'b0;
      single_click <= 1'b0;
      long_press   <= 1'b0;
      btn_held     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      btn_q        <= btn_state;
      press_pulse  <= press_n;
      single_click <= single_n;
      long_press   <= long_n;
      btn_held     <= held_n;
    end
  end

`ifdef BTN_DOUBLE_CLICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) double_click <= 1'b0;
    else        double_click <= double_n;
  end
`else
  assign double_click = 1'b0;
  logic unused_double;
  assign unused_double = double_n;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with LONG_CYCLES=16, GAP_CYCLES=8.
// Expectations follow BTN_DOUBLE_CLICK_EN when it is defined for the build.
module tb_button_event_decoder;

  localparam int K_PRESS  = 0;
  localparam int K_SINGLE = 1;
  localparam int K_DOUBLE = 2;
  localparam int K_LONG   = 3;
  localparam int K_HRISE  = 4;
  localparam int K_HFALL  = 5;
`ifdef BTN_DOUBLE_CLICK_EN
  localparam int SDLY = 7;
`else
  localparam int SDLY = 0;
`endif

  typedef struct {int kind; int cyc;} ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_state = 1'b1;
  logic press_pulse, single_click, double_click, long_press, btn_held;

  ev_t  sb[$];
  ev_t  e;
  int   cyc = 0;
  int   smp = 0;
  int   checks = 0;
  int   errors = 0;
  logic chk_zero = 1'b0;
  logic chk_end = 1'b0;
  logic held_prev = 1'b0;
  logic [5:0] ev;

  button_event_decoder #(.LONG_CYCLES(16), .GAP_CYCLES(8), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .btn_state(btn_state),
    .press_pulse(press_pulse), .single_click(single_click),
    .double_click(double_click), .long_press(long_press), .btn_held(btn_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_PRESS:  return "press_pulse";
      K_SINGLE: return "single_click";
      K_DOUBLE: return "double_click";
      K_LONG:   return "long_press";
      K_HRISE:  return "btn_held_rise";
      default:  return "btn_held_fall";
    endcase
  endfunction

  // Monitor: every observed pulse/edge pops the next expected event.
  always @(negedge clk) begin
    if (chk_zero) begin
      checks++;
      if ({press_pulse, single_click, double_click, long_press, btn_held} != 5'b0) begin
        errors++;
        $display("FAIL outputs_zero cycle %0d: got %b, required 00000", cyc,
                 {press_pulse, single_click, double_click, long_press, btn_held});
      end
    end
    ev = {~btn_held & held_prev, btn_held & ~held_prev, long_press, double_click, single_click, press_pulse};
    if (ev[3:1] != 3'b0) begin
      checks++;
      if ($countones(ev[3:1]) > 1) begin
        errors++;
        $display("FAIL exclusive cycle %0d: got events %b, required at most one", cyc, ev[3:1]);
      end
    end
    for (int k = 0; k < 6; k++) begin
      if (ev[k]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected cycle %0d: got %s, required none", cyc, kname(k));
        end else begin
          e = sb.pop_front();
          if (e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got %s@%0d, required %s@%0d", kname(k), cyc, kname(e.kind), e.cyc);
          end
        end
      end
    end
    if (chk_end) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL missing: got %0d events outstanding, required 0 (next %s@%0d)",
                 sb.size(), kname(sb[0].kind), sb[0].cyc);
      end
    end
    held_prev = btn_held;
  end

  task automatic push(input int kind, input int c);
    ev_t x;
    x.kind = kind;
    x.cyc  = c;
    sb.push_back(x);
  endtask

  // Drive one sample; smp is the cycle index of the edge that samples it.
  task automatic step(input logic v);
    @(negedge clk);
    btn_state = v;
    smp = cyc + 1;
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic short_press(input int hi, input int lo);
    step(1'b1);
    push(K_PRESS, smp);
    hold(1'b1, hi - 1);
    step(1'b0);
    push(K_SINGLE, smp + SDLY);
    hold(1'b0, lo - 1);
  endtask

  initial begin
    // held through reset, then kept held: nothing may fire
    chk_zero = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 40);
    chk_zero = 1'b0;
    hold(1'b0, 5);

    // press 5, release 20
    short_press(5, 20);

    // press 4, release 7, press 3, release
    step(1'b1); push(K_PRESS, smp);
    hold(1'b1, 3);
    step(1'b0);
`ifndef BTN_DOUBLE_CLICK_EN
    push(K_SINGLE, smp);
`endif
    hold(1'b0, 6);
    step(1'b1); push(K_PRESS, smp);
    hold(1'b1, 2);
    step(1'b0);
`ifdef BTN_DOUBLE_CLICK_EN
    push(K_DOUBLE, smp);
`else
    push(K_SINGLE, smp);
`endif
    hold(1'b0, 20);

    // press 4, release 8, press 3: gap timeout then a fresh sequence
    step(1'b1); push(K_PRESS, smp);
    hold(1'b1, 3);
    step(1'b0); push(K_SINGLE, smp + SDLY);
    hold(1'b0, 7);
    short_press(3, 20);

    // second press held 30 cycles
    step(1'b1); push(K_PRESS, smp);
    hold(1'b1, 3);
    step(1'b0);
`ifndef BTN_DOUBLE_CLICK_EN
    push(K_SINGLE, smp);
`endif
    hold(1'b0, 1);
    step(1'b1); push(K_PRESS, smp);
    for (int i = 1; i < 30; i++) begin
      step(1'b1);
`ifndef BTN_DOUBLE_CLICK_EN
      if (i == 15) begin
        push(K_LONG, smp);
        push(K_HRISE, smp);
      end
`endif
    end
    step(1'b0);
`ifdef BTN_DOUBLE_CLICK_EN
    push(K_DOUBLE, smp);
`else
    push(K_HFALL, smp);
`endif
    hold(1'b0, 20);

    // 15 high samples: click; 16+ high samples: long press
    short_press(15, 20);
    step(1'b1); push(K_PRESS, smp);
    for (int i = 1; i < 20; i++) begin
      step(1'b1);
      if (i == 15) begin
        push(K_LONG, smp);
        push(K_HRISE, smp);
      end
    end
    step(1'b0); push(K_HFALL, smp);
    hold(1'b0, 20);

    // reset in WAIT2 after 5 low samples
    step(1'b1); push(K_PRESS, smp);
    hold(1'b1, 3);
    step(1'b0);
`ifndef BTN_DOUBLE_CLICK_EN
    push(K_SINGLE, smp);
`endif
    hold(1'b0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_zero = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 20);
    chk_zero = 1'b0;
    short_press(4, 20);

    chk_end = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
